// File: rtl/run_control.sv
// Run-control and trap monitor: gates PC writes, latches trap cause/EPC, and
// handles host halt/resume/N-step plus free-running cycle and instret counters.
module run_control #(
  parameter int DATA_WIDTH = 64,
  parameter int EXC_WIDTH  = 8,
  parameter int ECALL_BIT  = 3,
  parameter int EBREAK_BIT = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int STEP_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [EXC_WIDTH-1:0]  exceptions_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  retire_i,
  input  logic                  halt_req_i,
  input  logic                  resume_i,
  input  logic                  step_i,
  input  logic [STEP_WIDTH-1:0] step_count_i,
  input  logic                  clear_i,
  output logic                  pc_we_o,
  output logic [2:0]            state_o,
  output logic                  halted_o,
  output logic                  error_o,
  output logic [EXC_WIDTH-1:0]  cause_o,
  output logic [DATA_WIDTH-1:0] epc_o,
  output logic [CNT_WIDTH-1:0]  cycle_cnt_o,
  output logic [CNT_WIDTH-1:0]  instret_o
);

  typedef enum logic [2:0] {
    S_RST   = 3'd0,
    S_RUN   = 3'd1,
    S_HALT  = 3'd2,
    S_ERROR = 3'd3,
    S_STEP  = 3'd4
  } state_t;

  // ECALL and EBREAK halt for the debugger; any other exception bit is fatal.
  localparam logic [EXC_WIDTH-1:0] BENIGN =
    (EXC_WIDTH'(1) << ECALL_BIT) | (EXC_WIDTH'(1) << EBREAK_BIT);

  state_t                state_q, state_d;
  logic [STEP_WIDTH-1:0] rem_q, rem_d;
  logic [EXC_WIDTH-1:0]  cause_q, cause_d;
  logic [DATA_WIDTH-1:0] epc_q, epc_d;
  logic [CNT_WIDTH-1:0]  cycle_q, instret_q;
  logic                  exc, err, active, commit, clr;

  assign exc    = |exceptions_i;
  assign err    = |(exceptions_i & ~BENIGN);
  assign active = (state_q == S_RUN) || (state_q == S_STEP);
  assign commit = active && retire_i && !exc && !halt_req_i;
  assign clr    = (state_q == S_ERROR) && clear_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_RST;
      rem_q   <= '0;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    case (state_q)
      S_RST: state_d = S_RUN;
      S_RUN, S_STEP: begin
        if (exc || halt_req_i) begin
          // Trap or host halt; a pending step count is abandoned.
          state_d = err ? S_ERROR : S_HALT;
          cause_d = exceptions_i;
          epc_d   = pc_i;
          rem_d   = '0;
        end else if (state_q == S_STEP && commit) begin
          rem_d = rem_q - STEP_WIDTH'(1);
          if (rem_q == STEP_WIDTH'(1)) begin
            state_d = S_HALT;
            cause_d = '0;
            epc_d   = pc_i + DATA_WIDTH'(4);
          end
        end
      end
      S_HALT: begin
        if (resume_i) begin
          state_d = S_RUN;
        end else if (step_i && step_count_i != '0) begin
          state_d = S_STEP;
          rem_d   = step_count_i;
        end
      end
      S_ERROR: if (clear_i) state_d = S_RST;
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else if (clr) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != S_RST) cycle_q <= cycle_q + CNT_WIDTH'(1);
      if (commit)           instret_q <= instret_q + CNT_WIDTH'(1);
    end
  end

  assign pc_we_o     = commit;
  assign state_o     = state_q;
  assign halted_o    = (state_q == S_HALT);
  assign error_o     = (state_q == S_ERROR);
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign cycle_cnt_o = cycle_q;
  assign instret_o   = instret_q;

endmodule

// File: tb/tb_run_control.sv
// Directed bench for run_control: a behavioural model checked every cycle,
// plus literal expectations taken from hand-worked scenarios.
module tb_run_control;
  localparam int DW = 64, EW = 8, CW = 64, SW = 16;

  logic          clk_i = 1'b0, rst_i = 1'b0;
  logic [EW-1:0] exceptions_i = '0;
  logic [DW-1:0] pc_i = '0;
  logic          retire_i = 1'b0, halt_req_i = 1'b0, resume_i = 1'b0, step_i = 1'b0, clear_i = 1'b0;
  logic [SW-1:0] step_count_i = '0;
  logic          pc_we_o, halted_o, error_o;
  logic [2:0]    state_o;
  logic [EW-1:0] cause_o;
  logic [DW-1:0] epc_o;
  logic [CW-1:0] cycle_cnt_o, instret_o;

  run_control dut (
    .clk_i(clk_i), .rst_i(rst_i), .exceptions_i(exceptions_i), .pc_i(pc_i),
    .retire_i(retire_i), .halt_req_i(halt_req_i), .resume_i(resume_i),
    .step_i(step_i), .step_count_i(step_count_i), .clear_i(clear_i),
    .pc_we_o(pc_we_o), .state_o(state_o), .halted_o(halted_o), .error_o(error_o),
    .cause_o(cause_o), .epc_o(epc_o), .cycle_cnt_o(cycle_cnt_o), .instret_o(instret_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode numbers are the architectural state codes.
  int          m_mode = 0;
  int          m_rem = 0;
  logic [7:0]  m_cause = '0;
  logic [63:0] m_epc = '0, m_cyc = '0, m_inst = '0;

  function automatic bit m_commit();
    return (m_mode == 1 || m_mode == 4) && retire_i && exceptions_i == 0 && !halt_req_i;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_mode = 0; m_rem = 0; m_cause = 0; m_epc = 0; m_cyc = 0; m_inst = 0;
    end else begin
      bit c, fatal;
      c = m_commit();
      fatal = (exceptions_i & ~8'h18) != 0;
      if (m_mode == 3 && clear_i) begin
        m_cyc = 0; m_inst = 0; m_mode = 0;
      end else begin
        if (m_mode != 0) m_cyc++;
        if (c) m_inst++;
        case (m_mode)
          0: m_mode = 1;
          1, 4: begin
            if (exceptions_i != 0 || halt_req_i) begin
              m_mode = fatal ? 3 : 2; m_cause = exceptions_i; m_epc = pc_i; m_rem = 0;
            end else if (m_mode == 4 && c) begin
              m_rem--;
              if (m_rem == 0) begin m_mode = 2; m_cause = 0; m_epc = pc_i + 4; end
            end
          end
          2: begin
            if (resume_i) m_mode = 1;
            else if (step_i && step_count_i != 0) begin m_mode = 4; m_rem = int'(step_count_i); end
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs are compared mid-cycle, well clear of edges and input changes.
  always @(negedge clk_i) begin
    chk("state", 64'(state_o), 64'(m_mode));
    chk("pc_we", 64'(pc_we_o), 64'(m_commit()));
    chk("halted", 64'(halted_o), 64'(m_mode == 2));
    chk("error", 64'(error_o), 64'(m_mode == 3));
    chk("cause", 64'(cause_o), 64'(m_cause));
    chk("epc", epc_o, m_epc);
    chk("cycle_cnt", cycle_cnt_o, m_cyc);
    chk("instret", instret_o, m_inst);
  end

  task automatic tick();
    @(posedge clk_i); #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 64'(state_o), 0);
    chk({tag, "_pc_we"}, 64'(pc_we_o), 0);
    chk({tag, "_halted"}, 64'(halted_o), 0);
    chk({tag, "_error"}, 64'(error_o), 0);
    chk({tag, "_cause"}, 64'(cause_o), 0);
    chk({tag, "_epc"}, epc_o, 0);
    chk({tag, "_cycle"}, cycle_cnt_o, 0);
    chk({tag, "_instret"}, instret_o, 0);
  endtask

  initial begin
    #1 rst_i = 1'b1;
    #1 chk_reset_vals("por");
    tick(); tick();
    // Release reset with retire already high: RST cycle, then 10 commits.
    rst_i = 1'b0; retire_i = 1'b1; pc_i = 64'h1000;
    #1 chk("rst_cycle_pc_we", 64'(pc_we_o), 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      #1 chk("run_pc_we", 64'(pc_we_o), 1);
      tick(); pc_i = pc_i + 4;
    end
    retire_i = 1'b0;
    tick();
    #1 chk("instret_10", instret_o, 10);
    chk("cycle_11", cycle_cnt_o, 11);

    // EBREAK halts without committing.
    exceptions_i = 8'h10; pc_i = 64'h8000_0040; retire_i = 1'b1;
    #1 chk("ebreak_pc_we", 64'(pc_we_o), 0);
    tick();
    exceptions_i = '0;
    #1 chk("ebreak_halted", 64'(halted_o), 1);
    chk("ebreak_cause", 64'(cause_o), 64'h10);
    chk("ebreak_epc", epc_o, 64'h8000_0040);
    chk("ebreak_instret", instret_o, 10);

    // Step 3 with retire pattern 1,0,1,1.
    step_i = 1'b1; step_count_i = 16'd3; retire_i = 1'b0;
    tick();
    step_i = 1'b0; pc_i = 64'h8000_0100;
    retire_i = 1'b1; tick(); pc_i = pc_i + 4;
    retire_i = 1'b0; tick();
    retire_i = 1'b1; tick(); pc_i = pc_i + 4;
    #1 chk("step_not_done", 64'(state_o), 4);
    tick(); retire_i = 1'b0;
    #1 chk("step_done_halted", 64'(halted_o), 1);
    chk("step_cause", 64'(cause_o), 0);
    chk("step_epc", epc_o, 64'h8000_010C);
    chk("step_instret", instret_o, 13);
    step_i = 1'b1; step_count_i = '0;
    tick(); step_i = 1'b0;
    #1 chk("step0_halted", 64'(halted_o), 1);

    // Illegal + ECALL is fatal; host inputs ignored until clear.
    resume_i = 1'b1; tick(); resume_i = 1'b0;
    exceptions_i = 8'h0A; retire_i = 1'b1; pc_i = 64'h2000;
    tick(); exceptions_i = '0;
    #1 chk("err_error", 64'(error_o), 1);
    chk("err_cause", 64'(cause_o), 64'h0A);
    resume_i = 1'b1; step_i = 1'b1; step_count_i = 16'd2;
    tick(); resume_i = 1'b0; step_i = 1'b0;
    #1 chk("err_sticky", 64'(state_o), 3);
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    #1 chk("clr_state", 64'(state_o), 0);
    chk("clr_cycle", cycle_cnt_o, 0);
    chk("clr_instret", instret_o, 0);
    tick();
    #1 chk("clr_run", 64'(state_o), 1);

    // Exception beats a simultaneous halt request; resume beats step.
    halt_req_i = 1'b1; exceptions_i = 8'h08; pc_i = 64'h3000;
    tick(); halt_req_i = 1'b0; exceptions_i = '0;
    #1 chk("hx_cause", 64'(cause_o), 64'h08);
    chk("hx_epc", epc_o, 64'h3000);
    resume_i = 1'b1; step_i = 1'b1; step_count_i = 16'd4;
    tick(); resume_i = 1'b0; step_i = 1'b0;
    #1 chk("resume_wins", 64'(state_o), 1);

    // Cycle counter wrap.
    retire_i = 1'b0;
    force dut.cycle_q = '1;
    m_cyc = '1;
    #1 release dut.cycle_q;
    tick();
    #1 chk("cycle_wrap", cycle_cnt_o, 0);

    // Host halt, step 5, then asynchronous reset mid-step.
    halt_req_i = 1'b1; pc_i = 64'h4000; tick(); halt_req_i = 1'b0;
    #1 chk("hh_epc", epc_o, 64'h4000);
    step_i = 1'b1; step_count_i = 16'd5; tick(); step_i = 1'b0;
    retire_i = 1'b1; tick(); tick();
    #1 chk("mid_step", 64'(state_o), 4);
    rst_i = 1'b1;
    #1 chk_reset_vals("async");
    tick(); rst_i = 1'b0; retire_i = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout: simulation did not finish, expected completion before 100000");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
